// File: rtl/mem_arb_pkg.sv
// Shared types and default timing for the unified-memory arbiter.
// Included by the counter and by the arbiter top.
package mem_arb_pkg;

   localparam int unsigned LATENCY_DEF      = 4;
   localparam int unsigned STARVE_LIMIT_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arb_counter.sv
// Loadable latency down-counter for the memory arbiter.
// zero_o flags the decrement that takes the count to zero.
module mem_arb_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_VAL = LATENCY_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load_i,
   input  logic [$clog2(MAX_VAL+1)-1:0]     load_val_i,
   input  logic                             dec_i,
   output logic                             zero_o
);

   localparam int unsigned W = $clog2(MAX_VAL+1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = dec_i && (cnt_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between fetch (IF) and data (DM).
// One access in flight at a time: grant/issue in IDLE, wait out the latency, pulse ready.
//
//   state | meaning
//   IDLE  | no access in flight; any request is granted and issued this cycle
//   WAIT  | access issued, counting down to the cycle mem_rdata is valid
//   RESP  | owner's ready pulses; back to IDLE next cycle
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LATENCY      = LATENCY_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [15:0] if_addr_i,
   output logic        if_ready_o,
   output logic [15:0] if_rdata_o,
   output logic        if_stall_o,
   input  logic        dm_req_i,
   input  logic        dm_wr_i,
   input  logic [15:0] dm_addr_i,
   input  logic [15:0] dm_wdata_i,
   output logic        dm_ready_o,
   output logic [15:0] dm_rdata_o,
   output logic        dm_stall_o,
   output logic        mem_en_o,
   output logic        mem_wr_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   input  logic [15:0] mem_rdata_i,
   output logic        err_o
);

   localparam int unsigned CW = $clog2(LATENCY+1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT+1);
   localparam logic [CW-1:0] LAT_LOAD   = CW'(LATENCY);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   logic          wr_q, wr_d;
   logic [15:0]   addr_q, addr_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [15:0]   if_rdata_q, if_rdata_d;
   logic [15:0]   dm_rdata_q, dm_rdata_d;
   logic          err_q, err_d;

   logic          cnt_load, cnt_dec, cnt_zero;
   logic          idle_ok, grant_dm, grant_if;
   logic          own_req, own_wr;
   logic [15:0]   own_addr;

   // Reset gates the grant so no command or stall escapes while rst_n is low.
   assign idle_ok  = rst_n && (state_q == ST_IDLE);
   assign grant_dm = idle_ok && dm_req_i && !(if_req_i && (streak_q == STARVE_MAX));
   assign grant_if = idle_ok && if_req_i && !grant_dm;

   assign own_req  = (owner_q == OWN_IF) ? if_req_i  : dm_req_i;
   assign own_addr = (owner_q == OWN_IF) ? if_addr_i : dm_addr_i;
   assign own_wr   = (owner_q == OWN_DM) ? dm_wr_i   : 1'b0;

   mem_arb_counter #(
      .MAX_VAL    (LATENCY)
   ) u_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (LAT_LOAD),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      streak_d    = streak_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      err_d       = err_q;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      mem_en_o    = 1'b0;
      mem_wr_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;

      case (state_q)
         ST_IDLE: begin
            if (grant_dm || grant_if) begin
               mem_en_o = 1'b1;
               cnt_load = 1'b1;
               state_d  = ST_WAIT;
               if (grant_dm) begin
                  owner_d     = OWN_DM;
                  wr_d        = dm_wr_i;
                  addr_d      = dm_addr_i;
                  mem_wr_o    = dm_wr_i;
                  mem_addr_o  = dm_addr_i;
                  mem_wdata_o = dm_wdata_i;
                  streak_d    = if_req_i ? (streak_q + SW'(1)) : '0;
               end else begin
                  owner_d    = OWN_IF;
                  wr_d       = 1'b0;
                  addr_d     = if_addr_i;
                  mem_addr_o = if_addr_i;
                  streak_d   = '0;
               end
               if (addr_d[0]) begin
                  err_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            cnt_dec = 1'b1;
            if (!own_req || (own_addr != addr_q) || (own_wr != wr_q)) begin
               err_d = 1'b1;
            end
            if (cnt_zero) begin
               state_d = ST_RESP;
               if (owner_q == OWN_IF) begin
                  if_rdata_d = mem_rdata_i;
               end else if (!wr_q) begin
                  dm_rdata_d = mem_rdata_i;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_NONE;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         streak_q   <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         streak_q   <= streak_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         err_q      <= err_d;
      end
   end

   assign if_ready_o = (state_q == ST_RESP) && (owner_q == OWN_IF);
   assign dm_ready_o = (state_q == ST_RESP) && (owner_q == OWN_DM);
   assign if_stall_o = rst_n && if_req_i && !if_ready_o;
   assign dm_stall_o = rst_n && dm_req_i && !dm_ready_o;
   assign if_rdata_o = if_rdata_q;
   assign dm_rdata_o = dm_rdata_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// slot-based reference model of the arbiter and a behavioural memory macro.
module tb_mem_arbiter;

   localparam int L  = 2;
   localparam int SL = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req, if_ready, if_stall;
   logic [15:0] if_addr, if_rdata;
   logic        dm_req, dm_wr, dm_ready, dm_stall;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_wr, err;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] mem_arr [0:511];
   logic [15:0] shadow  [0:511];
   int          pend_cnt;
   logic [15:0] pend_data;

   always #5 clk = ~clk;

   mem_arbiter #(.LATENCY(L), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready),
      .if_rdata_o(if_rdata), .if_stall_o(if_stall),
      .dm_req_i(dm_req), .dm_wr_i(dm_wr), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ready_o(dm_ready), .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall),
      .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .err_o(err)
   );

   function automatic logic [15:0] init_word(int i);
      return 16'(i * 257) ^ 16'h5A5A;
   endfunction

   // Memory macro: read data valid only in the cycle exactly L after mem_en, noise otherwise.
   initial begin
      logic s_en, s_wr, s_rst;
      logic [15:0] s_addr, s_wdata;
      pend_cnt  = 0;
      pend_data = '0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         s_en = mem_en; s_wr = mem_wr; s_addr = mem_addr; s_wdata = mem_wdata; s_rst = rst_n;
         @(posedge clk);
         if (pend_cnt > 0) pend_cnt--;
         if (!s_rst || !rst_n) begin
            pend_cnt = 0;
         end else if (s_en) begin
            if (s_wr) mem_arr[s_addr[9:1]] = s_wdata;
            else begin
               pend_cnt  = L;
               pend_data = mem_arr[s_addr[9:1]];
            end
         end
         #1 mem_rdata = (pend_cnt == 1) ? pend_data : 16'($urandom);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      logic [15:0] obs [8];
      string nm [8];
      rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0;
      if_addr = 16'h0010; dm_addr = 16'h0100; dm_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      obs = '{16'(mem_en), 16'(if_ready), 16'(dm_ready), 16'(if_stall),
              16'(dm_stall), 16'(err), if_rdata, dm_rdata};
      nm  = '{"rst_mem_en", "rst_if_ready", "rst_dm_ready", "rst_if_stall",
              "rst_dm_stall", "rst_err", "rst_if_rdata", "rst_dm_rdata"};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs[i] !== 16'h0) $display("FAIL %s: got %h expected 0000", nm[i], obs[i]);
         else n_pass++;
      end
      if_req = 1'b0; dm_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_if_read();
      if_req = 1'b1; if_addr = 16'h0010;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (mem_en !== (k == 0)) $display("FAIL ifrd_mem_en k=%0d got %b", k, mem_en); else n_pass++;
         n_checks++; if (if_stall !== (k < 3)) $display("FAIL ifrd_stall k=%0d got %b", k, if_stall); else n_pass++;
         n_checks++; if (if_ready !== (k == 3)) $display("FAIL ifrd_ready k=%0d got %b", k, if_ready); else n_pass++;
         if (k == 0) begin
            n_checks++;
            if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) $display("FAIL ifrd_cmd got addr %h wr %b expected 0010/0", mem_addr, mem_wr);
            else n_pass++;
         end
         if (k >= 3) begin
            n_checks++; if (if_rdata !== 16'hBEEF) $display("FAIL ifrd_rdata k=%0d got %h expected beef", k, if_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 3) if_req = 1'b0;
      end
   endtask

   task automatic test_both();
      if_req = 1'b1; if_addr = 16'h0010;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         n_checks++; if (mem_en !== (k == 0 || k == 4)) $display("FAIL both_mem_en k=%0d got %b", k, mem_en); else n_pass++;
         n_checks++; if (dm_ready !== (k == 3)) $display("FAIL both_dm_ready k=%0d got %b", k, dm_ready); else n_pass++;
         n_checks++; if (if_ready !== (k == 7)) $display("FAIL both_if_ready k=%0d got %b", k, if_ready); else n_pass++;
         n_checks++; if (if_stall !== (k < 7)) $display("FAIL both_if_stall k=%0d got %b", k, if_stall); else n_pass++;
         if (k == 0) begin
            n_checks++; if (mem_addr !== 16'h0100) $display("FAIL both_first_addr got %h expected 0100", mem_addr); else n_pass++;
         end
         if (k == 4) begin
            n_checks++; if (mem_addr !== 16'h0010) $display("FAIL both_second_addr got %h expected 0010", mem_addr); else n_pass++;
         end
         if (k == 3) begin
            n_checks++; if (dm_rdata !== 16'hCAFE) $display("FAIL both_dm_rdata got %h expected cafe", dm_rdata); else n_pass++;
         end
         if (k == 7) begin
            n_checks++; if (if_rdata !== 16'hBEEF) $display("FAIL both_if_rdata got %h expected beef", if_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 3) dm_req = 1'b0;
         if (k == 7) if_req = 1'b0;
      end
   endtask

   task automatic test_starve();
      int exp_ord [5] = '{2, 2, 2, 1, 2};
      int ord [5];
      int ngr = 0;
      int cyc = 0;
      logic saw_if, saw_dm;
      if_req = 1'b1; if_addr = 16'h0010;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
      while (cyc < 60 && (ngr < 5 || if_req || dm_req)) begin
         @(negedge clk);
         if (mem_en && ngr < 5) begin
            ord[ngr] = (mem_addr == 16'h0100) ? 2 : 1;
            ngr++;
         end
         saw_if = if_ready; saw_dm = dm_ready;
         @(posedge clk); #1;
         if (ngr >= 5) begin
            if (saw_dm) dm_req = 1'b0;
            if (saw_if) if_req = 1'b0;
         end
         cyc++;
      end
      n_checks++;
      if (ngr < 5 || if_req || dm_req) $display("FAIL starve_timeout got %0d grants expected 5", ngr);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ngr > i && ord[i] !== exp_ord[i]) $display("FAIL starve_order grant %0d got %0d expected %0d (1=IF 2=DM)", i, ord[i], exp_ord[i]);
         else if (ngr > i) n_pass++;
         else $display("FAIL starve_order grant %0d missing", i);
      end
      if_req = 1'b0; dm_req = 1'b0;
      n_checks++; if (err !== 1'b0) $display("FAIL starve_err got %b expected 0", err); else n_pass++;
   endtask

   task automatic test_write();
      dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         n_checks++; if (mem_en !== (k == 0)) $display("FAIL wr_mem_en k=%0d got %b", k, mem_en); else n_pass++;
         n_checks++; if (dm_ready !== (k == 3)) $display("FAIL wr_dm_ready k=%0d got %b", k, dm_ready); else n_pass++;
         n_checks++; if (dm_stall !== (k < 3)) $display("FAIL wr_dm_stall k=%0d got %b", k, dm_stall); else n_pass++;
         if (k == 0) begin
            n_checks++;
            if (mem_wr !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0200)
               $display("FAIL wr_cmd got wr %b data %h addr %h expected 1/1234/0200", mem_wr, mem_wdata, mem_addr);
            else n_pass++;
         end
         if (k >= 3) begin
            n_checks++; if (dm_rdata !== 16'hCAFE) $display("FAIL wr_dm_rdata_held k=%0d got %h expected cafe", k, dm_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 3) begin dm_req = 1'b0; dm_wr = 1'b0; end
      end
   endtask

   task automatic test_reset_wait();
      logic [15:0] obs [8];
      string nm [8];
      if_req = 1'b1; if_addr = 16'h0010;
      @(negedge clk);
      n_checks++; if (mem_en !== 1'b1) $display("FAIL rw_issue got %b expected 1", mem_en); else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      obs = '{16'(mem_en), 16'(if_ready), 16'(dm_ready), 16'(if_stall),
              16'(dm_stall), 16'(err), if_rdata, dm_rdata};
      nm  = '{"rw_mem_en", "rw_if_ready", "rw_dm_ready", "rw_if_stall",
              "rw_dm_stall", "rw_err", "rw_if_rdata", "rw_dm_rdata"};
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (obs[i] !== 16'h0) $display("FAIL %s: got %h expected 0000", nm[i], obs[i]);
         else n_pass++;
      end
      if_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (if_ready !== 1'b0 || mem_en !== 1'b0) $display("FAIL rw_quiet k=%0d got ready %b en %b expected 0/0", k, if_ready, mem_en);
         else n_pass++;
         @(posedge clk); #1;
      end
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++; if (mem_en !== (k == 0)) $display("FAIL rw_fresh_en k=%0d got %b", k, mem_en); else n_pass++;
         n_checks++; if (dm_ready !== (k == 3)) $display("FAIL rw_fresh_ready k=%0d got %b", k, dm_ready); else n_pass++;
         if (k == 3) begin
            n_checks++; if (dm_rdata !== 16'hCAFE) $display("FAIL rw_fresh_rdata got %h expected cafe", dm_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 3) dm_req = 1'b0;
      end
   endtask

   task automatic test_err();
      n_checks++; if (err !== 1'b0) $display("FAIL err_initial got %b expected 0", err); else n_pass++;
      if_req = 1'b1; if_addr = 16'h0011;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++; if (err !== (k >= 1)) $display("FAIL err_unaligned k=%0d got %b", k, err); else n_pass++;
         n_checks++; if (if_ready !== (k == 3)) $display("FAIL err_unal_ready k=%0d got %b", k, if_ready); else n_pass++;
         if (k == 3) begin
            n_checks++; if (if_rdata !== 16'hBEEF) $display("FAIL err_unal_rdata got %h expected beef", if_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 3) if_req = 1'b0;
      end
      rst_n = 1'b0; #1;
      n_checks++; if (err !== 1'b0) $display("FAIL err_clear got %b expected 0", err); else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0100;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         n_checks++; if (err !== (k >= 2)) $display("FAIL err_drop k=%0d got %b", k, err); else n_pass++;
         n_checks++; if (dm_ready !== (k == 3)) $display("FAIL err_drop_ready k=%0d got %b", k, dm_ready); else n_pass++;
         if (k == 3) begin
            n_checks++; if (dm_rdata !== 16'hCAFE) $display("FAIL err_drop_rdata got %h expected cafe", dm_rdata); else n_pass++;
         end
         @(posedge clk); #1;
         if (k == 0) dm_req = 1'b0;
      end
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   // Reference: one access occupies L+2 slots; a free slot with any request issues at once.
   task automatic test_random();
      int free_c = 0, rdy_c = -1, own = 0, streak = 0;
      logic g_wr = 1'b0;
      logic [15:0] g_addr = '0, g_wd = '0, exp_rd = '0;
      logic [15:0] exp_if_rd = '0, exp_dm_rd = '0;
      logic exp_en, exp_if_rdy, exp_dm_rdy, saw_if, saw_dm;
      for (int i = 0; i < 512; i++) begin
         mem_arr[i] = init_word(i);
         shadow[i]  = init_word(i);
      end
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         exp_en = 1'b0;
         if (c >= free_c && (if_req || dm_req)) begin
            exp_en = 1'b1;
            if (dm_req && !(if_req && streak == SL)) begin
               own = 2; streak = if_req ? streak + 1 : 0;
               g_addr = dm_addr; g_wr = dm_wr; g_wd = dm_wdata;
            end else begin
               own = 1; streak = 0;
               g_addr = if_addr; g_wr = 1'b0;
            end
            free_c = c + L + 2;
            rdy_c  = c + L + 1;
            if (g_wr) shadow[g_addr[9:1]] = g_wd;
            else exp_rd = shadow[g_addr[9:1]];
         end
         exp_if_rdy = (c == rdy_c) && (own == 1);
         exp_dm_rdy = (c == rdy_c) && (own == 2);
         if (exp_if_rdy) exp_if_rd = exp_rd;
         if (exp_dm_rdy && !g_wr) exp_dm_rd = exp_rd;
         n_checks++; if (mem_en !== exp_en) $display("FAIL rnd_mem_en c=%0d got %b expected %b", c, mem_en, exp_en); else n_pass++;
         if (exp_en) begin
            n_checks++;
            if (mem_addr !== g_addr || mem_wr !== g_wr || (g_wr && mem_wdata !== g_wd))
               $display("FAIL rnd_cmd c=%0d got %h/%b/%h expected %h/%b/%h", c, mem_addr, mem_wr, mem_wdata, g_addr, g_wr, g_wd);
            else n_pass++;
         end
         n_checks++; if (if_ready !== exp_if_rdy) $display("FAIL rnd_if_ready c=%0d got %b expected %b", c, if_ready, exp_if_rdy); else n_pass++;
         n_checks++; if (dm_ready !== exp_dm_rdy) $display("FAIL rnd_dm_ready c=%0d got %b expected %b", c, dm_ready, exp_dm_rdy); else n_pass++;
         n_checks++; if (if_rdata !== exp_if_rd) $display("FAIL rnd_if_rdata c=%0d got %h expected %h", c, if_rdata, exp_if_rd); else n_pass++;
         n_checks++; if (dm_rdata !== exp_dm_rd) $display("FAIL rnd_dm_rdata c=%0d got %h expected %h", c, dm_rdata, exp_dm_rd); else n_pass++;
         n_checks++;
         if (if_stall !== (if_req && !exp_if_rdy) || dm_stall !== (dm_req && !exp_dm_rdy))
            $display("FAIL rnd_stall c=%0d got %b%b", c, if_stall, dm_stall);
         else n_pass++;
         saw_if = if_ready; saw_dm = dm_ready;
         @(posedge clk); #1;
         if (!if_req || saw_if) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = {6'b0, 9'($urandom_range(0, 511)), 1'b0};
         end
         if (!dm_req || saw_dm) begin
            dm_req   = 1'($urandom_range(0, 1));
            dm_wr    = 1'($urandom_range(0, 1));
            dm_addr  = {6'b0, 9'($urandom_range(0, 511)), 1'b0};
            dm_wdata = 16'($urandom);
         end
      end
      n_checks++; if (err !== 1'b0) $display("FAIL rnd_err got %b expected 0", err); else n_pass++;
      for (int k = 0; k < 20 && (if_req || dm_req); k++) begin
         @(negedge clk);
         saw_if = if_ready; saw_dm = dm_ready;
         @(posedge clk); #1;
         if (saw_if) if_req = 1'b0;
         if (saw_dm) dm_req = 1'b0;
      end
   endtask

   initial begin
      if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
      if_addr = '0; dm_addr = '0; dm_wdata = '0;
      for (int i = 0; i < 512; i++) mem_arr[i] = init_word(i);
      mem_arr[16'h0010 >> 1] = 16'hBEEF;
      mem_arr[16'h0100 >> 1] = 16'hCAFE;
      test_reset();
      test_if_read();
      test_both();
      test_starve();
      test_write();
      test_reset_wait();
      test_err();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
